gray_updown_ctr: RTL and testbench

GRAY_UPDOWN_CTR -- requirements
Module: gray_updown_ctr

---
 rtl/gray_pkg.sv | 19 +
 rtl/gray_updown_ctr_gray2bin.sv | 16 +
 rtl/gray_updown_ctr.sv | 90 +++++++++
 tb/tb_gray_updown_ctr.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and Gray/binary conversion helpers for the Gray up/down counter.
package gray_pkg;

  typedef enum logic {GRAY_WRAP, GRAY_SAT} gray_mode_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_updown_ctr_gray2bin.sv
// Combinational Gray-to-binary converter: XOR prefix chain from the MSB down.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  always_comb begin
    o_bin[WIDTH-1] = i_gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      o_bin[i] = o_bin[i+1] ^ i_gray[i];
    end
  end

endmodule

// File: rtl/gray_updown_ctr.sv
// Up/down counter with registered Gray output, wrap or saturate at LIMIT.
// Define GRAY_CTR_BIN_OUT_EN to add the registered binary output q_bin.
module gray_updown_ctr
  import gray_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               SATURATE = 0,
  parameter logic [WIDTH-1:0] LIMIT    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
`ifdef GRAY_CTR_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] q_bin
`endif
);

  localparam gray_mode_e MODE = (SATURATE != 0) ? GRAY_SAT : GRAY_WRAP;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_tc_next;
  logic             w_at_bound;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .i_gray (load_val),
    .o_bin  (w_load_bin)
  );

  assign w_at_bound = up ? (r_cnt == LIMIT) : (r_cnt == '0);

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    w_cnt_next = r_cnt;
    w_tc_next  = 1'b0;
    if (load) begin
      w_cnt_next = (w_load_bin > LIMIT) ? LIMIT : w_load_bin;
    end else if (en) begin
      w_tc_next = w_at_bound;
      if (up) begin
        if (w_at_bound) w_cnt_next = (MODE == GRAY_SAT) ? LIMIT : '0;
        else            w_cnt_next = r_cnt + 1'b1;
      end else begin
        if (w_at_bound) w_cnt_next = (MODE == GRAY_SAT) ? '0 : LIMIT;
        else            w_cnt_next = r_cnt - 1'b1;
      end
    end
  end

  // q is encoded from the next count so it is a true register, not a decode of r_cnt.
  assign w_q_next = WIDTH'(bin2gray(32'(w_cnt_next)));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_q   <= '0;
      r_tc  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_q   <= w_q_next;
      r_tc  <= w_tc_next;
    end
  end

  assign q  = r_q;
  assign tc = r_tc;

`ifdef GRAY_CTR_BIN_OUT_EN
  logic [WIDTH-1:0] r_q_bin;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_q_bin <= '0;
    else        r_q_bin <= w_cnt_next;
  end

  assign q_bin = r_q_bin;
`endif

endmodule

// File: tb/tb_gray_updown_ctr.sv
// Directed self-checking bench: default wrap counter, saturating counter and LIMIT=9 counter.
module tb_gray_updown_ctr;

  logic       clk;
  logic       reset;
  logic       en0, up0, ld0, en1, up1, ld1, en2, up2, ld2;
  logic [3:0] lv0, lv1, lv2;
  logic [3:0] q0, q1, q2;
  logic       tc0, tc1, tc2;
`ifdef GRAY_CTR_BIN_OUT_EN
  logic [3:0] qb0, qb1, qb2;
`endif

  int n_total = 0;
  int n_bad   = 0;

  gray_updown_ctr #(.WIDTH(4)) u_wrap (
    .clk(clk), .reset(reset), .en(en0), .up(up0), .load(ld0), .load_val(lv0),
    .q(q0), .tc(tc0)
`ifdef GRAY_CTR_BIN_OUT_EN
    , .q_bin(qb0)
`endif
  );

  gray_updown_ctr #(.WIDTH(4), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en1), .up(up1), .load(ld1), .load_val(lv1),
    .q(q1), .tc(tc1)
`ifdef GRAY_CTR_BIN_OUT_EN
    , .q_bin(qb1)
`endif
  );

  gray_updown_ctr #(.WIDTH(4), .LIMIT(4'd9)) u_lim (
    .clk(clk), .reset(reset), .en(en2), .up(up2), .load(ld2), .load_val(lv2),
    .q(q2), .tc(tc2)
`ifdef GRAY_CTR_BIN_OUT_EN
    , .q_bin(qb2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] gtab [16];
    logic [3:0] prev;
    gtab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
             4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    {en0, up0, ld0, en1, up1, ld1, en2, up2, ld2} = '0;
    lv0 = '0; lv1 = '0; lv2 = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_q0", 32'(q0), 0);
    check("rst_tc0", 32'(tc0), 0);
    check("rst_q1", 32'(q1), 0);
    check("rst_q2", 32'(q2), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Free-running up count through a full wrap.
    en0 = 1'b1; up0 = 1'b1;
    prev = 4'd0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("cnt_q_%0d", k), 32'(q0), 32'(gtab[k % 16]));
      check($sformatf("cnt_tc_%0d", k), 32'(tc0), (k == 16) ? 1 : 0);
      check($sformatf("cnt_1bit_%0d", k), $countones(q0 ^ prev), 1);
      prev = q0;
    end
    en0 = 1'b0;
    step();
    check("hold_q0", 32'(q0), 6);
    check("hold_tc0", 32'(tc0), 0);

    // Saturating counter held at 0 going down, then at LIMIT going up.
    en1 = 1'b1; up1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("sat_lo_q", 32'(q1), 0);
      check("sat_lo_tc", 32'(tc1), 1);
    end
    up1 = 1'b1;
    step();
    check("sat_dir_q", 32'(q1), 1);
    check("sat_dir_tc", 32'(tc1), 0);
    en1 = 1'b0; ld1 = 1'b1; lv1 = 4'b1000;
    step();
    check("sat_ld_q", 32'(q1), 8);
    check("sat_ld_tc", 32'(tc1), 0);
    ld1 = 1'b0; en1 = 1'b1; up1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("sat_hi_q", 32'(q1), 8);
      check("sat_hi_tc", 32'(tc1), 1);
    end
    en1 = 1'b0;
    step();
    check("sat_idle_tc", 32'(tc1), 0);

    // LIMIT=9 counter: wrap 9 -> 0, clamp of a large load, down-wrap to 9.
    ld2 = 1'b1; lv2 = 4'b1100;
    step();
    check("lim_ld8_q", 32'(q2), 12);
    ld2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
    step();
    check("lim_9_q", 32'(q2), 13);
    check("lim_9_tc", 32'(tc2), 0);
`ifdef GRAY_CTR_BIN_OUT_EN
    check("lim_9_qb", 32'(qb2), 9);
`endif
    step();
    check("lim_wrap_q", 32'(q2), 0);
    check("lim_wrap_tc", 32'(tc2), 1);
`ifdef GRAY_CTR_BIN_OUT_EN
    check("lim_wrap_qb", 32'(qb2), 0);
`endif
    en2 = 1'b0; ld2 = 1'b1; lv2 = 4'b1010;
    step();
    check("lim_clamp_q", 32'(q2), 13);
    check("lim_clamp_tc", 32'(tc2), 0);
`ifdef GRAY_CTR_BIN_OUT_EN
    check("lim_clamp_qb", 32'(qb2), 9);
`endif
    lv2 = 4'b0000;
    step();
    ld2 = 1'b0; en2 = 1'b1; up2 = 1'b0;
    step();
    check("lim_dn_q", 32'(q2), 13);
    check("lim_dn_tc", 32'(tc2), 1);
    en2 = 1'b0;

    // Load beats enable on the same edge.
    ld0 = 1'b1; lv0 = 4'b1100; en0 = 1'b1; up0 = 1'b1;
    step();
    check("ld_pri_q", 32'(q0), 12);
    check("ld_pri_tc", 32'(tc0), 0);
`ifdef GRAY_CTR_BIN_OUT_EN
    check("ld_pri_qb", 32'(qb0), 8);
`endif

    // Direction toggled every cycle starting from 5.
    en0 = 1'b0; lv0 = 4'b0111;
    step();
    check("ld5_q", 32'(q0), 7);
    ld0 = 1'b0; en0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      up0 = (k % 2 == 0);
      step();
      check($sformatf("tog_q_%0d", k), 32'(q0), (k % 2 == 0) ? 5 : 7);
      check($sformatf("tog_tc_%0d", k), 32'(tc0), 0);
    end

    // Down-wrap from 0 to LIMIT, then asynchronous reset mid-cycle.
    en0 = 1'b0; ld0 = 1'b1; lv0 = 4'b0000;
    step();
    check("ld0_q", 32'(q0), 0);
    ld0 = 1'b0; en0 = 1'b1; up0 = 1'b0;
    step();
    check("dnwrap_q", 32'(q0), 8);
    check("dnwrap_tc", 32'(tc0), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_q0", 32'(q0), 0);
    check("arst_tc0", 32'(tc0), 0);
    check("arst_q1", 32'(q1), 0);
    check("arst_q2", 32'(q2), 0);
`ifdef GRAY_CTR_BIN_OUT_EN
    check("arst_qb0", 32'(qb0), 0);
`endif
    up0 = 1'b1;
    @(negedge clk) reset = 1'b1;
    step();
    check("resume_q", 32'(q0), 1);
    check("resume_tc", 32'(tc0), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
